// File: rtl/seg_scan_driver.sv
// seg_scan_driver: 4-digit seven-segment scan driver with anti-ghost blanking, PWM brightness and blink.
// Rev 1.0
`default_nettype none

module seg_scan_driver #(
  parameter int SCAN_DIV     = 100000,
  parameter int BLANK_CYC    = 1000,
  parameter int BLINK_FRAMES = 125
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] d0,
  input  logic [7:0] d1,
  input  logic [7:0] d2,
  input  logic [7:0] d3,
  input  logic [3:0] dp_mask,
  input  logic [3:0] blink_mask,
  input  logic       blink_en,
  input  logic [2:0] bright,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp,
  output logic       frame_tick
);

  localparam int             CW       = $clog2(SCAN_DIV);
  localparam int             FW       = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0]  CNT_MAX  = CW'(SCAN_DIV - 1);
  localparam logic [FW-1:0]  FRM_MAX  = FW'(BLINK_FRAMES - 1);
  localparam logic [31:0]    SPAN     = 32'(SCAN_DIV - BLANK_CYC);
  localparam logic [31:0]    BLANK_LO = 32'(BLANK_CYC);
  localparam logic [3:0]     AN_ONE   = 4'b0001;
  localparam logic [7:0]     CODE_RST = 8'h10;

  logic [CW-1:0]  cnt;
  logic [1:0]     idx;
  logic [FW-1:0]  frame_cnt;
  logic           phase;

  logic [3:0][7:0] sh_code;
  logic [3:0]      sh_dp;
  logic [3:0]      sh_blink;
  logic            sh_blink_en;
  logic [2:0]      sh_bright;

  logic           frame_start;
  logic           frame_end;
  logic [7:0]     code;
  logic [6:0]     pat;
  logic [31:0]    on_len;
  logic [31:0]    cnt32;
  logic           in_window;
  logic           blinked;
  logic           lit;

  assign frame_start = (cnt == '0) && (idx == 2'd0);
  assign frame_end   = (cnt == CNT_MAX) && (idx == 2'd3);

  // Scan position and blink timing; the blink counter advances at the end of each frame so
  // the first frame after reset is frame 0 of the lit half-period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      idx       <= 2'd0;
      frame_cnt <= '0;
      phase     <= 1'b0;
    end else begin
      if (cnt == CNT_MAX) begin
        cnt <= '0;
        idx <= idx + 2'd1;
      end else begin
        cnt <= cnt + CW'(1);
      end
      if (frame_end) begin
        if (frame_cnt == FRM_MAX) begin
          frame_cnt <= '0;
          phase     <= ~phase;
        end else begin
          frame_cnt <= frame_cnt + FW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_code     <= {4{CODE_RST}};
      sh_dp       <= 4'h0;
      sh_blink    <= 4'h0;
      sh_blink_en <= 1'b0;
      sh_bright   <= 3'd0;
    end else if (frame_start) begin
      sh_code     <= {d3, d2, d1, d0};
      sh_dp       <= dp_mask;
      sh_blink    <= blink_mask;
      sh_blink_en <= blink_en;
      sh_bright   <= bright;
    end
  end

  assign code = sh_code[idx];

  always_comb begin
    pat = 7'h00;
    if (code[7]) begin
      pat = code[6:0];
    end else begin
      case (code)
        8'h00:   pat = 7'h3F;
        8'h01:   pat = 7'h06;
        8'h02:   pat = 7'h5B;
        8'h03:   pat = 7'h4F;
        8'h04:   pat = 7'h66;
        8'h05:   pat = 7'h6D;
        8'h06:   pat = 7'h7D;
        8'h07:   pat = 7'h07;
        8'h08:   pat = 7'h7F;
        8'h09:   pat = 7'h6F;
        8'h0A:   pat = 7'h77;
        8'h0B:   pat = 7'h7C;
        8'h0C:   pat = 7'h39;
        8'h0D:   pat = 7'h5E;
        8'h0E:   pat = 7'h79;
        8'h0F:   pat = 7'h71;
        8'h11:   pat = 7'h40;
        default: pat = 7'h00;
      endcase
    end
  end

  // Lit window starts after the blanking gap, so idx changes only while anodes are off.
  assign on_len    = (SPAN * (32'(sh_bright) + 32'd1)) >> 3;
  assign cnt32     = 32'(cnt);
  assign in_window = (cnt32 >= BLANK_LO) && (cnt32 < (BLANK_LO + on_len));
  assign blinked   = sh_blink_en & sh_blink[idx] & phase;
  assign lit       = in_window & ~blinked;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an         <= 4'hF;
      seg        <= 7'h7F;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= frame_start;
      if (lit) begin
        an  <= ~(AN_ONE << idx);
        seg <= ~pat;
        dp  <= ~sh_dp[idx];
      end else begin
        an  <= 4'hF;
        seg <= 7'h7F;
        dp  <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: directed + randomized scan checks against a cycle-position reference model.
// Rev 1.0
`default_nettype none
`timescale 1ns/1ps

module tb_seg_scan_driver;

  localparam int SD    = 16;
  localparam int BC    = 2;
  localparam int BF    = 2;
  localparam int FRAME = 4 * SD;
  localparam logic [12:0] ALL_OFF = {4'hF, 7'h7F, 1'b1, 1'b0};

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] d0, d1, d2, d3;
  logic [3:0] dp_mask, blink_mask;
  logic       blink_en;
  logic [2:0] bright;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;
  logic       frame_tick;

  seg_scan_driver #(.SCAN_DIV(SD), .BLANK_CYC(BC), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .reset(reset),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .dp_mask(dp_mask), .blink_mask(blink_mask), .blink_en(blink_en), .bright(bright),
    .seg(seg), .an(an), .dp(dp), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n = 0;

  // Reference state: per-frame snapshot of the game-side inputs.
  logic [7:0] m_code [4];
  logic [3:0] m_dp, m_bm;
  logic       m_ben;
  logic [2:0] m_br;

  function automatic logic [6:0] glyph(input logic [7:0] c);
    if (c >= 8'h80) return c[6:0];
    case (c)
      8'h00: return 7'b0111111;  8'h01: return 7'b0000110;
      8'h02: return 7'b1011011;  8'h03: return 7'b1001111;
      8'h04: return 7'b1100110;  8'h05: return 7'b1101101;
      8'h06: return 7'b1111101;  8'h07: return 7'b0000111;
      8'h08: return 7'b1111111;  8'h09: return 7'b1101111;
      8'h0A: return 7'b1110111;  8'h0B: return 7'b1111100;
      8'h0C: return 7'b0111001;  8'h0D: return 7'b1011110;
      8'h0E: return 7'b1111001;  8'h0F: return 7'b1110001;
      8'h11: return 7'b1000000;
      default: return 7'b0000000;
    endcase
  endfunction

  // Expected {an,seg,dp,frame_tick} after edge k (k edges since reset release).
  function automatic logic [12:0] model(input int k);
    int pos    = k % SD;
    int slot   = (k / SD) % 4;
    int frame  = k / FRAME;
    int on_len = ((SD - BC) * (int'(m_br) + 1)) / 8;
    bit ph     = ((frame / BF) % 2) == 1;
    bit lit    = (pos >= BC) && (pos < BC + on_len) && !(m_ben && m_bm[slot] && ph);
    logic [3:0] one = 4'b0001;
    logic tick = (k % FRAME) == 0;
    if (!lit) return {4'hF, 7'h7F, 1'b1, tick};
    return {~(one << slot), ~glyph(m_code[slot]), ~m_dp[slot], tick};
  endfunction

  task automatic check(input string tag, input logic [12:0] exp);
    checks++;
    assert ({an, seg, dp, frame_tick} === exp)
    else begin
      errors++;
      $error("FAIL %s at n=%0d: observed an/seg/dp/tick=%h expected %h", tag, n, {an, seg, dp, frame_tick}, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_code[i] = 8'h10;
    m_dp = 4'h0; m_bm = 4'h0; m_ben = 1'b0; m_br = 3'd0;
  endtask

  task automatic step(input string tag);
    if (n % FRAME == 0) begin
      m_code[0] = d0; m_code[1] = d1; m_code[2] = d2; m_code[3] = d3;
      m_dp = dp_mask; m_bm = blink_mask; m_ben = blink_en; m_br = bright;
    end
    @(posedge clk);
    #1;
    check(tag, model(n));
    n++;
  endtask

  task automatic run(input int cycles, input string tag);
    for (int i = 0; i < cycles; i++) step(tag);
  endtask

  task automatic run_to(input int pos, input string tag);
    for (int i = 0; i < FRAME && (n % FRAME) != pos; i++) step(tag);
  endtask

  task automatic pulse_reset(input string tag);
    reset = 1'b1;
    #1;
    check({tag, "_now"}, ALL_OFF);
    @(posedge clk);
    #1;
    check({tag, "_held"}, ALL_OFF);
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    model_reset();
  endtask

  function automatic logic [7:0] rand_code();
    case ($urandom_range(0, 3))
      0:       return 8'($urandom_range(0, 15));
      1:       return 8'h11;
      2:       return 8'h80 | 8'($urandom_range(0, 127));
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  task automatic randomize_inputs();
    d0 = rand_code(); d1 = rand_code(); d2 = rand_code(); d3 = rand_code();
    dp_mask    = 4'($urandom_range(0, 15));
    blink_mask = 4'($urandom_range(0, 15));
    blink_en   = 1'($urandom_range(0, 1));
    bright     = 3'($urandom_range(0, 7));
  endtask

  initial begin
    reset = 1'b1;
    d0 = 8'h08; d1 = 8'h08; d2 = 8'h08; d3 = 8'h08;
    dp_mask = 4'h0; blink_mask = 4'h0; blink_en = 1'b0; bright = 3'd7;
    model_reset();
    #12;
    check("reset", ALL_OFF);
    @(negedge clk);
    reset = 1'b0;
    n = 0;

    run(2 * FRAME, "all_eights");

    d0 = 8'h83; d1 = 8'h11; d2 = 8'h40; d3 = 8'h0A;
    run(2 * FRAME, "raw_dash_blank_A");

    bright = 3'd0; run(FRAME, "bright0");
    bright = 3'd3; run(FRAME, "bright3");
    bright = 3'd7; run(FRAME, "bright7");

    d0 = 8'h08; d1 = 8'h08; d2 = 8'h08; d3 = 8'h08;
    blink_en = 1'b1; blink_mask = 4'b0001; dp_mask = 4'b0001;
    pulse_reset("blink_rst");
    run(5 * FRAME, "blink");

    blink_en = 1'b0; dp_mask = 4'h0; d1 = 8'h01;
    run_to(0, "mid_align");
    run(FRAME + 37, "mid_before");
    d1 = 8'h02;
    run_to(0, "mid_old");
    run(FRAME, "mid_new");

    run_to(39, "rst_align");
    pulse_reset("mid_slot");
    run(FRAME + 16, "after_rst");

    for (int f = 0; f < 20; f++) begin
      randomize_inputs();
      run($urandom_range(1, FRAME - 1), "rand_a");
      randomize_inputs();
      run_to(0, "rand_b");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
